// File: rtl/mem_pkg.sv
// Shared constants for the word-to-byte memory controller: FSM state encoding and
// default RAM geometry.
package mem_pkg;

  localparam int unsigned DefaultAddSize  = 11;
  localparam int unsigned DefaultDataSize = 8;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLo   = 3'd1;
  localparam logic [2:0] StHi   = 3'd2;
  localparam logic [2:0] StCap  = 3'd3;
  localparam logic [2:0] StRsp  = 3'd4;

endpackage

// File: rtl/mem_word_ctrl.sv
// Splits byte/word requests into one or two byte accesses on a registered-read byte RAM.
// Optional MEM_WORD_CTRL_ALIGN_CHK_EN adds rsp_err flagging odd-address word accesses.
module mem_word_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADD_SIZE  = DefaultAddSize,
  parameter int unsigned DATA_SIZE = DefaultDataSize
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic                   req_word,
  input  logic [ADD_SIZE-1:0]    req_addr,
  input  logic [2*DATA_SIZE-1:0] req_wdata,
  output logic                   rsp_valid,
`ifdef MEM_WORD_CTRL_ALIGN_CHK_EN
  output logic                   rsp_err,
`endif
  output logic [2*DATA_SIZE-1:0] rsp_rdata,
  output logic                   ram_write_en,
  output logic [ADD_SIZE-1:0]    ram_write_adress,
  output logic [DATA_SIZE-1:0]   ram_data_in,
  output logic                   ram_rd_en,
  output logic [ADD_SIZE-1:0]    ram_rd_adress,
  input  logic [DATA_SIZE-1:0]   ram_data_out
);

  logic [2:0]             state_q, state_d;
  logic                   we_q, we_d;
  logic                   word_q, word_d;
  logic [ADD_SIZE-1:0]    addr_q, addr_d;
  logic [2*DATA_SIZE-1:0] wdata_q, wdata_d;
  logic [2*DATA_SIZE-1:0] rdata_q, rdata_d;

  logic                   access;
  logic [ADD_SIZE-1:0]    acc_addr;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          word_d  = req_word;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = StLo;
        end
      end
      StLo: begin
        if (word_q)    state_d = StHi;
        else if (we_q) state_d = StRsp;
        else           state_d = StCap;
      end
      StHi: begin
        // RAM read is registered: the LO byte arrives while we are in HI.
        if (!we_q) rdata_d[DATA_SIZE-1:0] = ram_data_out;
        state_d = we_q ? StRsp : StCap;
      end
      StCap: begin
        if (word_q) rdata_d[2*DATA_SIZE-1:DATA_SIZE] = ram_data_out;
        else        rdata_d = {{DATA_SIZE{1'b0}}, ram_data_out};
        state_d = StRsp;
      end
      StRsp:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      word_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes come only from state and latched fields, so reset drops them at once.
  always_comb begin
    access           = (state_q == StLo) || (state_q == StHi);
    acc_addr         = (state_q == StHi) ? addr_q + ADD_SIZE'(1) : addr_q;
    ram_write_en     = access && we_q;
    ram_rd_en        = access && !we_q;
    ram_write_adress = acc_addr;
    ram_rd_adress    = acc_addr;
    ram_data_in      = (state_q == StHi) ? wdata_q[2*DATA_SIZE-1:DATA_SIZE]
                                         : wdata_q[DATA_SIZE-1:0];
    req_ready        = (state_q == StIdle);
    rsp_valid        = (state_q == StRsp);
    rsp_rdata        = rdata_q;
  end

`ifdef MEM_WORD_CTRL_ALIGN_CHK_EN
  // Misaligned words still complete; the flag is informational only.
  always_comb begin
    rsp_err = (state_q == StRsp) && word_q && addr_q[0];
  end
`endif

endmodule
